// File: rtl/branch_predictor_if.sv
// Fetch-lookup and resolve-update bundle between the core and the branch predictor.
// The core drives the PCs and outcomes; the predictor returns the prediction and statistics.
interface branch_predictor_if;
    logic        [31:0] if_pc;
    logic               predict_taken;
    logic        [31:0] predict_PC;
    logic        [31:0] upd_pc;
    logic        [1:0]  upd_state;
    logic               upd_pred_taken;
    logic        [31:0] upd_target;
    logic               upd_wrong;
    logic        [31:0] stat_branches;
    logic        [31:0] stat_mispredicts;

    modport master (
        output if_pc, upd_pc, upd_state, upd_pred_taken, upd_target, upd_wrong,
        input  predict_taken, predict_PC, stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, upd_pc, upd_state, upd_pred_taken, upd_target, upd_wrong,
        output predict_taken, predict_PC, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter predictor with a branch-target buffer.
// Lookup is purely combinational; updates land on the edge that samples the outcome.
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic            clk,
    input  logic            rstn,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_OK   = 2'b01;
    localparam logic [1:0] ST_TNT  = 2'b10;
    localparam logic [1:0] ST_NTT  = 2'b11;

    logic             valid_q  [DEPTH];
    logic             valid_d  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [1:0]       cnt_q    [DEPTH];
    logic [1:0]       cnt_d    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      target_d [DEPTH];

    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit, act_taken;
    logic [1:0]       cnt_cur;

    assign lk_idx  = bp.if_pc[TAG_LO-1:2];
    assign lk_tag  = bp.if_pc[TAG_HI:TAG_LO];
    assign upd_idx = bp.upd_pc[TAG_LO-1:2];
    assign upd_tag = bp.upd_pc[TAG_HI:TAG_LO];

    // Lookup reads only the registered table, so a same-cycle update is not bypassed.
    assign lk_hit            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bp.predict_taken  = lk_hit && cnt_q[lk_idx][1];
    assign bp.predict_PC     = bp.predict_taken ? target_q[lk_idx] : bp.if_pc + 32'd4;
    assign bp.stat_branches    = stat_branches_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;

    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign act_taken = (bp.upd_state == ST_NTT) ||
                       ((bp.upd_state == ST_OK) && bp.upd_pred_taken);
    assign cnt_cur   = cnt_q[upd_idx];

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latches).
        valid_d            = valid_q;
        tag_d              = tag_q;
        cnt_d              = cnt_q;
        target_d           = target_q;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;

        if (bp.upd_state != ST_NONE) begin
            stat_branches_d = stat_branches_q + 32'd1;
            if (bp.upd_wrong) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end

            if (upd_hit) begin
                // 01 steps toward the carried prediction, 10 decays, 11 strengthens;
                // in every case that is the direction actually taken.
                unique case (bp.upd_state)
                    ST_TNT:  cnt_d[upd_idx] = (cnt_cur == 2'b00) ? cnt_cur : cnt_cur - 2'd1;
                    ST_NTT:  cnt_d[upd_idx] = (cnt_cur == 2'b11) ? cnt_cur : cnt_cur + 2'd1;
                    default: begin
                        if (bp.upd_pred_taken) begin
                            cnt_d[upd_idx] = (cnt_cur == 2'b11) ? cnt_cur : cnt_cur + 2'd1;
                        end else begin
                            cnt_d[upd_idx] = (cnt_cur == 2'b00) ? cnt_cur : cnt_cur - 2'd1;
                        end
                    end
                endcase
                if (act_taken) begin
                    target_d[upd_idx] = bp.upd_target;
                end
            end else if (act_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bp.upd_target;
                cnt_d[upd_idx]    = 2'b10;
            end
        end
    end

    // NOTE: the table is reset explicitly (valid, tag, cnt, target) because the
    // architectural reset state is defined for every entry, not just the valid bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                cnt_q[i]    <= 2'b01;
                target_q[i] <= '0;
            end
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            cnt_q              <= cnt_d;
            target_q           <= target_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = &{1'b0, bp.upd_pc[31:TAG_HI+1], bp.upd_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, counter saturation, retargeting,
// aliasing, same-cycle lookup/update and asynchronous reset.
module tb_branch_predictor;
    logic clk;
    logic rstn;
    int   n_checks;
    int   n_pass;

    branch_predictor_if bp ();

    branch_predictor #(.IDX_W(4), .TAG_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bp   (bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [1:0] st, input logic pt,
                           input logic [31:0] tgt, input logic wrong);
        bp.upd_pc         = pc;
        bp.upd_state      = st;
        bp.upd_pred_taken = pt;
        bp.upd_target     = tgt;
        bp.upd_wrong      = wrong;
    endtask

    // Take one edge, then retire the update so it is applied exactly once.
    task automatic tick();
        @(posedge clk);
        #1;
        bp.upd_state = 2'b00;
    endtask

    task automatic look(input logic [31:0] pc);
        bp.if_pc = pc;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rstn     = 1'b0;
        bp.if_pc = 32'h100;
        set_upd(32'h0, 2'b00, 1'b0, 32'h0, 1'b0);

        // Reset state
        #12;
        look(32'h100);
        check("rst_taken", {31'b0, bp.predict_taken}, 32'h0);
        check("rst_pc", bp.predict_PC, 32'h104);
        check("rst_br", bp.stat_branches, 32'h0);
        check("rst_mis", bp.stat_mispredicts, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Allocate on taken miss: cnt=10
        set_upd(32'h100, 2'b11, 1'b0, 32'h80, 1'b1);
        tick();
        look(32'h100);
        check("alloc_taken", {31'b0, bp.predict_taken}, 32'h1);
        check("alloc_pc", bp.predict_PC, 32'h80);
        check("alloc_br", bp.stat_branches, 32'd1);
        check("alloc_mis", bp.stat_mispredicts, 32'd1);

        // Correct taken: cnt 10 -> 11
        set_upd(32'h100, 2'b01, 1'b1, 32'h80, 1'b0);
        tick();
        look(32'h100);
        check("strong_taken", {31'b0, bp.predict_taken}, 32'h1);
        check("strong_br", bp.stat_branches, 32'd2);

        // Decay 11 -> 10 -> 01
        set_upd(32'h100, 2'b10, 1'b1, 32'h0, 1'b1);
        tick();
        look(32'h100);
        check("decay1_taken", {31'b0, bp.predict_taken}, 32'h1);
        check("decay1_pc", bp.predict_PC, 32'h80);
        set_upd(32'h100, 2'b10, 1'b1, 32'h0, 1'b1);
        tick();
        look(32'h100);
        check("decay2_taken", {31'b0, bp.predict_taken}, 32'h0);
        check("decay2_pc", bp.predict_PC, 32'h104);
        check("decay2_mis", bp.stat_mispredicts, 32'd3);

        // 01 -> 00 -> 00 (saturate), then 11 -> 01: still not taken
        set_upd(32'h100, 2'b10, 1'b0, 32'h0, 1'b0);
        tick();
        set_upd(32'h100, 2'b10, 1'b0, 32'h0, 1'b0);
        tick();
        set_upd(32'h100, 2'b11, 1'b0, 32'h80, 1'b0);
        tick();
        look(32'h100);
        check("sat_lo_taken", {31'b0, bp.predict_taken}, 32'h0);
        check("sat_lo_br", bp.stat_branches, 32'd7);
        // 01 -> 10: taken again
        set_upd(32'h100, 2'b11, 1'b0, 32'h80, 1'b0);
        tick();
        look(32'h100);
        check("wk_taken", {31'b0, bp.predict_taken}, 32'h1);
        check("wk_pc", bp.predict_PC, 32'h80);

        // Not-taken miss does not allocate
        set_upd(32'h200, 2'b10, 1'b1, 32'h900, 1'b0);
        tick();
        look(32'h200);
        check("ntmiss_taken", {31'b0, bp.predict_taken}, 32'h0);
        check("ntmiss_pc", bp.predict_PC, 32'h204);
        check("ntmiss_br", bp.stat_branches, 32'd9);

        // Not-a-branch: no statistics change even with upd_wrong set
        set_upd(32'h300, 2'b00, 1'b1, 32'h700, 1'b1);
        tick();
        look(32'h300);
        check("none_br", bp.stat_branches, 32'd9);
        check("none_mis", bp.stat_mispredicts, 32'd3);
        check("none_taken", {31'b0, bp.predict_taken}, 32'h0);

        // JALR retarget on a hit
        set_upd(32'h100, 2'b01, 1'b1, 32'h400, 1'b1);
        tick();
        look(32'h100);
        check("jalr_pc", bp.predict_PC, 32'h400);
        check("jalr_mis", bp.stat_mispredicts, 32'd4);

        // Same index, different tag: miss
        look(32'h140);
        check("alias_miss_taken", {31'b0, bp.predict_taken}, 32'h0);
        check("alias_miss_pc", bp.predict_PC, 32'h144);
        // Same index and tag, different upper bits: accepted as hit
        look(32'h4100);
        check("alias_hit_pc", bp.predict_PC, 32'h400);

        // Same-cycle update and lookup: old prediction now, new one next cycle
        set_upd(32'h200, 2'b11, 1'b0, 32'h300, 1'b1);
        look(32'h200);
        check("same_old_taken", {31'b0, bp.predict_taken}, 32'h0);
        check("same_old_pc", bp.predict_PC, 32'h204);
        tick();
        look(32'h200);
        check("same_new_taken", {31'b0, bp.predict_taken}, 32'h1);
        check("same_new_pc", bp.predict_PC, 32'h300);
        check("same_br", bp.stat_branches, 32'd11);

        // Asynchronous reset mid-cycle with an update pending
        @(negedge clk);
        set_upd(32'h100, 2'b11, 1'b0, 32'h500, 1'b1);
        #2;
        rstn = 1'b0;
        look(32'h100);
        check("arst_taken", {31'b0, bp.predict_taken}, 32'h0);
        check("arst_pc", bp.predict_PC, 32'h104);
        check("arst_br", bp.stat_branches, 32'h0);
        check("arst_mis", bp.stat_mispredicts, 32'h0);
        @(posedge clk);
        #1;
        bp.upd_state = 2'b00;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        look(32'h100);
        check("post_rst_pc", bp.predict_PC, 32'h104);
        look(32'h200);
        check("post_rst_pc2", bp.predict_PC, 32'h204);
        check("post_rst_br", bp.stat_branches, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the five-stage RISC-V core: direct-mapped table of 2-bit saturating counters plus branch-target buffer. Combinationally supplies `predict_taken`/`predict_PC` to IF for the current fetch PC. Updates its tables one edge after the control unit reports the branch outcome as the 2-bit prediction-state code. Also keeps branch and mispredict statistics counters.

## Interface
- `IDX_W`, 4: index bits; table depth = 2^IDX_W entries.
- `TAG_W`, 8: stored tag bits per entry.
- `clk` input 1: single clock; all state updates on rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `if_pc` input 32: PC being fetched this cycle.
- `predict_taken` output 1: lookup prediction for `if_pc`.
- `predict_PC` output 32: predicted next PC for `if_pc`.
- `upd_pc` input 32: PC of the resolved control-transfer instruction.
- `upd_state` input 2: outcome code. 00 = not a branch, 01 = direction predicted correctly, 10 = predicted taken / actually not taken, 11 = predicted not-taken / actually taken.
- `upd_pred_taken` input 1: `predict_taken` value carried down the pipeline with the instruction.
- `upd_target` input 32: resolved jump/branch target.
- `upd_wrong` input 1: resolved mispredict flag (direction or JALR target).
- `stat_branches` output 32: count of updates with `upd_state != 00`.
- `stat_mispredicts` output 32: count of those updates with `upd_wrong = 1`.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`. Per entry: `valid`, `tag`, `cnt[1:0]`, `target[31:0]`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Saturating at 00 and 11.
- Lookup (combinational):
  - hit = `valid & tag match` at `if_pc`.
  - `predict_taken = hit & cnt[1]`.
  - `predict_PC = predict_taken ? target : if_pc + 4`, computed mod 2^32.
- Actual-taken decode:
  - `act_taken = (upd_state == 11) | (upd_state == 01 & upd_pred_taken)`.
  - `upd_state == 10` means not taken.
- Update on a clock edge with `upd_state != 00`:
  - **Hit at upd_pc:**
    - 01: step counter toward `upd_pred_taken`.
    - 10: decrement counter.
    - 11: increment counter.
    - If `act_taken`, write `target <= upd_target` as well; this covers a JALR target change.
  - **Miss, `act_taken = 1`:** allocate the entry, replacing any existing one: `valid = 1`, tag, `target = upd_target`, `cnt = 10`.
  - **Miss, `act_taken = 0`:** no table write.
- `upd_state == 00`: no table write and no statistics change.
- `stat_branches` increments by 1 on each edge with `upd_state != 00`. `stat_mispredicts` increments by 1 when that also has `upd_wrong = 1`. Both wrap 0xFFFFFFFF -> 0.

## Timing
- Lookup is zero-latency from `if_pc`; no registered prediction path.
- Update is written at the rising edge that samples `upd_*`. It is visible to lookup in the following cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update entry; no bypass.
- Reset (`rstn = 0`, any time, including mid-update), applied asynchronously:
  - All `valid = 0`, `cnt = 01`, `tag = 0`, `target = 0`.
  - Both statistics counters = 0.
  - Consequently `predict_taken = 0` and `predict_PC = if_pc + 4` while in reset.
- Any update in flight during reset is discarded. The first update is taken on the first rising edge after `rstn` rises.
- Aliasing: a different PC with the same index but a different tag is a miss. A matching tag from a different full PC is accepted as a hit; this is an architectural limitation, not an error.

## Test plan
- **Reset:** drive `rstn = 0` then release; `if_pc = 0x100` -> `predict_taken = 0`, `predict_PC = 0x104`, both stats = 0.
- **Allocate, then strengthen:**
  - `upd_pc = 0x100`, `upd_state = 11`, `upd_pred_taken = 0`, `upd_target = 0x80`, `upd_wrong = 1` -> next cycle `if_pc = 0x100` gives `predict_taken = 1`, `predict_PC = 0x80`; `stat_branches = 1`, `stat_mispredicts = 1`.
  - Repeat with `upd_state = 01`, `upd_pred_taken = 1` -> counter 11.
- **Saturation/decay:**
  - From `cnt = 11`, two updates with `upd_state = 10` -> counter 01, `predict_taken = 0`.
  - Two more -> counter 00.
  - One 11 update -> counter 01, still not taken.
- **Not-taken miss:** `upd_state = 10` on an untouched PC `0x200` -> no allocation; lookup of `0x200` is still not taken; `stat_branches` increments.
- **JALR retarget and aliasing:**
  - Hit entry at `0x100` with target `0x80`; `upd_state = 01`, `upd_pred_taken = 1`, `upd_target = 0x400`, `upd_wrong = 1` -> `predict_PC = 0x400`, mispredict count +1.
  - `if_pc = 0x140` (same index, different tag) -> miss.
- **Simultaneous and async reset:**
  - Update and lookup on the same index in the same cycle -> old prediction that cycle, new one the next cycle.
  - Assert `rstn = 0` mid-cycle during an update -> all state cleared immediately; the update is lost.
